// File: rtl/care_pkg.sv
// Shared constants for the care-action path: stat indices, action codes,
// per-action request payloads and the request FSM state encoding.
package care_pkg;

    localparam logic [2:0] STAT_HUNGER    = 3'd0;
    localparam logic [2:0] STAT_HAPPINESS = 3'd1;
    localparam logic [2:0] STAT_HEALTH    = 3'd2;
    localparam logic [2:0] STAT_HYGIENE   = 3'd3;
    localparam logic [2:0] STAT_ENERGY    = 3'd4;
    localparam logic [2:0] STAT_SOCIAL    = 3'd5;

    localparam logic [2:0] ACT_FEED     = 3'd0;
    localparam logic [2:0] ACT_PLAY     = 3'd1;
    localparam logic [2:0] ACT_MEDICINE = 3'd2;
    localparam logic [2:0] ACT_BATH     = 3'd3;
    localparam logic [2:0] ACT_SLEEP    = 3'd4;
    localparam logic [2:0] ACT_CHAT     = 3'd5;

    localparam logic [3:0] FEED_AMT      = 4'd4;
    localparam logic [3:0] PLAY_AMT1     = 4'd3;
    localparam logic [3:0] PLAY_AMT2     = 4'd1;
    localparam logic [3:0] MEDICINE_BASE = 4'd2;
    localparam logic [3:0] BATH_AMT      = 4'd5;
    localparam logic [3:0] SLEEP_AMT     = 4'd6;
    localparam logic [3:0] CHAT_AMT1     = 4'd3;
    localparam logic [3:0] CHAT_AMT2     = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE1   = 2'd1,
        ST_ISSUE2   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] sel1;
        logic [3:0] amt1;
        logic       has2;
        logic [2:0] sel2;
        logic [3:0] amt2;
    } payload_t;

    // Lowest-index pressed action among bits 0..5 wins; bits 6..7 never start one.
    function automatic logic [3:0] pick_action(input logic [7:0] press);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 5; i >= 0; i--) begin
            if (press[i]) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    // Request payload for an action; medicine amount is 2 + rnd[1:0].
    function automatic payload_t action_payload(input logic [2:0] act, input logic [1:0] rnd);
        payload_t p;
        p = '0;
        case (act)
            ACT_FEED:     begin p.sel1 = STAT_HUNGER;    p.amt1 = FEED_AMT; end
            ACT_PLAY:     begin p.sel1 = STAT_HAPPINESS; p.amt1 = PLAY_AMT1;
                                p.has2 = 1'b1; p.sel2 = STAT_SOCIAL; p.amt2 = PLAY_AMT2; end
            ACT_MEDICINE: begin p.sel1 = STAT_HEALTH;    p.amt1 = MEDICINE_BASE + {2'b00, rnd}; end
            ACT_BATH:     begin p.sel1 = STAT_HYGIENE;   p.amt1 = BATH_AMT; end
            ACT_SLEEP:    begin p.sel1 = STAT_ENERGY;    p.amt1 = SLEEP_AMT; end
            ACT_CHAT:     begin p.sel1 = STAT_SOCIAL;    p.amt1 = CHAT_AMT1;
                                p.has2 = 1'b1; p.sel2 = STAT_HAPPINESS; p.amt2 = CHAT_AMT2; end
            default:      p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioning: two-flop synchroniser, one stability counter shared by
// all bits, debounced vector and one-cycle rising-edge press pulses.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] buttons,
    output logic [7:0] press
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] STABLE_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]    sync_a;
    logic [7:0]    sync_b;
    logic [7:0]    sync_prev;
    logic [7:0]    debounced;
    logic [7:0]    debounced_prev;
    logic [DW-1:0] stable_cnt;

    // Bring the asynchronous buttons into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= buttons;
            sync_b <= sync_a;
        end
    end

    // Any change restarts the count; a full stable window loads the debounced vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_prev  <= '0;
            stable_cnt <= '0;
            debounced  <= '0;
        end else begin
            sync_prev <= sync_b;
            if (sync_b != sync_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt == STABLE_LAST) begin
                debounced <= sync_b;
            end else begin
                stable_cnt <= stable_cnt + DW'(1);
            end
        end
    end

    // Remember the previous debounced vector for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) debounced_prev <= '0;
        else          debounced_prev <= debounced;
    end

    assign press = debounced & ~debounced_prev;

endmodule

// File: rtl/care_actions.sv
// Care-action request generator. Debounced button presses become one or two
// stat-decrement requests followed by a cooldown.
// Optional build macro CARE_ACTIONS_BONUS_EN: random[4]=1 at acceptance adds
// 1 (saturating at 15) to the primary amount.
// Handshake: req_valid/req_sel/req_amt are held stable until the cycle where
// req_valid & req_ready are both high; that cycle is the transfer. req_valid
// never drops without a transfer except on reset.
module care_actions
    import care_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int COOLDOWN_CYCLES = 27000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] buttons,
    input  logic [4:0] random,
    output logic       req_valid,
    output logic [2:0] req_sel,
    output logic [3:0] req_amt,
    input  logic       req_ready,
    output logic       busy,
    output logic [2:0] last_action,
    output state_t     state
);
    localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES - 1);

    logic [7:0]    press;
    logic [3:0]    pick;
    payload_t      start_payload;
    state_t        state_q;
    state_t        state_next;
    logic [CW-1:0] cool_cnt;
    logic          has2_q;
    logic [2:0]    sel2_q;
    logic [3:0]    amt2_q;
    logic          transfer;
    logic          unused_bits;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .buttons (buttons),
        .press   (press)
    );

    assign unused_bits = ^{random[4:2], press[7:6]};

    // Select the winning action and build its payload for this cycle.
    always_comb begin
        pick          = pick_action(press);
        start_payload = action_payload(pick[2:0], random[1:0]);
`ifdef CARE_ACTIONS_BONUS_EN
        if (random[4] && (start_payload.amt1 != 4'hF)) begin
            start_payload.amt1 = start_payload.amt1 + 4'd1;
        end
`else
`endif
    end

    assign transfer = req_valid && req_ready;

    // Next-state logic for the request sequencer.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:     if (pick[3])     state_next = ST_ISSUE1;
            ST_ISSUE1:   if (transfer)    state_next = has2_q ? ST_ISSUE2 : ST_COOLDOWN;
            ST_ISSUE2:   if (transfer)    state_next = ST_COOLDOWN;
            ST_COOLDOWN: if (cool_cnt == '0) state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_next;
    end

    // Payload registers, last action and cooldown counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_sel     <= '0;
            req_amt     <= '0;
            has2_q      <= 1'b0;
            sel2_q      <= '0;
            amt2_q      <= '0;
            last_action <= '0;
            cool_cnt    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && pick[3]) begin
                last_action <= pick[2:0];
                req_sel     <= start_payload.sel1;
                req_amt     <= start_payload.amt1;
                has2_q      <= start_payload.has2;
                sel2_q      <= start_payload.sel2;
                amt2_q      <= start_payload.amt2;
            end else if ((state_q == ST_ISSUE1) && transfer && has2_q) begin
                req_sel <= sel2_q;
                req_amt <= amt2_q;
            end

            if ((state_next == ST_COOLDOWN) && (state_q != ST_COOLDOWN)) begin
                cool_cnt <= COOL_LOAD;
            end else if ((state_q == ST_COOLDOWN) && (cool_cnt != '0)) begin
                cool_cnt <= cool_cnt - CW'(1);
            end
        end
    end

    assign req_valid = (state_q == ST_ISSUE1) || (state_q == ST_ISSUE2);
    assign busy      = (state_q != ST_IDLE);
    assign state     = state_q;

endmodule

// File: tb/tb_care_actions.sv
// Directed bench for care_actions with short debounce and cooldown windows.
module tb_care_actions;
    import care_pkg::*;

    localparam int DEB  = 4;
    localparam int COOL = 8;
`ifdef CARE_ACTIONS_BONUS_EN
    localparam int BONUS = 1;
`else
    localparam int BONUS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] buttons = '0;
    logic [4:0] random = '0;
    logic       req_valid;
    logic [2:0] req_sel;
    logic [3:0] req_amt;
    logic       req_ready = 1'b0;
    logic       busy;
    logic [2:0] last_action;
    state_t     state;

    int total = 0;
    int bad = 0;

    logic [6:0] exp_q[$];

    care_actions #(
        .DEBOUNCE_CYCLES(DEB),
        .COOLDOWN_CYCLES(COOL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .buttons     (buttons),
        .random      (random),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_amt     (req_amt),
        .req_ready   (req_ready),
        .busy        (busy),
        .last_action (last_action),
        .state       (state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every transfer must match the head of exp_q; payload must
    // hold while valid is stalled.
    logic       prev_hold = 1'b0;
    logic [6:0] prev_pay = '0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_hold) begin
                check("hold_valid", int'(req_valid), 1);
                check("hold_payload", int'({req_sel, req_amt}), int'(prev_pay));
            end
            if (req_valid && req_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got sel=%0d amt=%0d expected none", req_sel, req_amt);
                end else begin
                    check("xfer_payload", int'({req_sel, req_amt}), int'(exp_q.pop_front()));
                end
            end
            prev_hold = req_valid && !req_ready;
            prev_pay  = {req_sel, req_amt};
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Driver helpers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] btn;
        logic [4:0] rnd;
        int         hold;
        int         lag;
        int         n;
        logic [2:0] sel1;
        logic [3:0] amt1;
        logic [2:0] sel2;
        logic [3:0] amt2;
        int         busy_cyc;
        logic [2:0] last;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit ok;
        int vcnt;
        int bcnt;

        vecs[0]  = '{8'h01, 5'b00000, 10, 0, 1, 3'd0, 4'd4, 3'd0, 4'd0, 9, 3'd0};
        vecs[1]  = '{8'h02, 5'b00000, 10, 5, 2, 3'd1, 4'd3, 3'd5, 4'd1, 15, 3'd1};
        vecs[2]  = '{8'h04, 5'b00011, 10, 0, 1, 3'd2, 4'd5, 3'd0, 4'd0, 9, 3'd2};
        vecs[3]  = '{8'h08, 5'b00000, 10, 2, 1, 3'd3, 4'd5, 3'd0, 4'd0, 11, 3'd3};
        vecs[4]  = '{8'h10, 5'b00000, 10, 0, 1, 3'd4, 4'd6, 3'd0, 4'd0, 9, 3'd4};
        vecs[5]  = '{8'h20, 5'b00000, 10, 1, 2, 3'd5, 4'd3, 3'd1, 4'd1, 11, 3'd5};
        vecs[6]  = '{8'h09, 5'b00000, 10, 0, 1, 3'd0, 4'd4, 3'd0, 4'd0, 9, 3'd0};
        vecs[7]  = '{8'h40, 5'b00000, 10, 0, 0, 3'd0, 4'd0, 3'd0, 4'd0, 0, 3'd0};
        vecs[8]  = '{8'h04, 5'b10011, 10, 0, 1, 3'd2, 4'(5 + BONUS), 3'd0, 4'd0, 9, 3'd2};
        vecs[9]  = '{8'h01, 5'b00000, 2, 0, 0, 3'd0, 4'd0, 3'd0, 4'd0, 0, 3'd2};
        vecs[10] = '{8'h01, 5'b10000, 10, 0, 1, 3'd0, 4'(4 + BONUS), 3'd0, 4'd0, 9, 3'd0};

        // Reset state
        step(3);
        check("rst_valid", int'(req_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sel", int'(req_sel), 0);
        check("rst_amt", int'(req_amt), 0);
        check("rst_last", int'(last_action), 0);
        check("rst_state", int'(state), int'(ST_IDLE));
        reset_n = 1'b1;
        step(2);

        // Table-driven single actions
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].n >= 1) exp_q.push_back({vecs[v].sel1, vecs[v].amt1});
            if (vecs[v].n >= 2) exp_q.push_back({vecs[v].sel2, vecs[v].amt2});
            random    = vecs[v].rnd;
            buttons   = vecs[v].btn;
            req_ready = 1'b0;
            vcnt = 0;
            bcnt = 0;
            for (int c = 0; c < 50; c++) begin
                if (c == vecs[v].hold) buttons = '0;
                if (req_valid) vcnt++;
                req_ready = (vcnt > vecs[v].lag);
                if (busy) bcnt++;
                step(1);
            end
            check($sformatf("v%0d_pending", v), exp_q.size(), 0);
            check($sformatf("v%0d_busy_cycles", v), bcnt, vecs[v].busy_cyc);
            check($sformatf("v%0d_last", v), int'(last_action), int'(vecs[v].last));
            check($sformatf("v%0d_idle", v), int'(state), int'(ST_IDLE));
            exp_q.delete();
        end

        // Press during cooldown is dropped; a held button does not re-trigger
        random    = '0;
        req_ready = 1'b0;
        exp_q.push_back({3'd0, 4'd4});
        buttons = 8'h01;
        wait_valid(20, ok);
        check("cd_feed_valid", int'(ok), 1);
        buttons = 8'h09;
        step(3);
        req_ready = 1'b1;
        step(40);
        check("cd_feed_done", exp_q.size(), 0);
        check("cd_idle", int'(busy), 0);
        check("cd_last", int'(last_action), 0);
        buttons = '0;
        step(15);
        exp_q.push_back({3'd3, 4'd5});
        buttons = 8'h08;
        step(10);
        buttons = '0;
        step(30);
        check("cd_bath_done", exp_q.size(), 0);
        check("cd_bath_last", int'(last_action), 3);
        exp_q.delete();

        // Reset while the secondary request is pending
        req_ready = 1'b0;
        exp_q.push_back({3'd1, 4'd3});
        buttons = 8'h02;
        wait_valid(20, ok);
        check("rs_play_valid", int'(ok), 1);
        req_ready = 1'b1;
        step(1);
        req_ready = 1'b0;
        check("rs_state_issue2", int'(state), int'(ST_ISSUE2));
        check("rs_sec_payload", int'({req_sel, req_amt}), int'({3'd5, 4'd1}));
        buttons = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rs_valid_low", int'(req_valid), 0);
        check("rs_state_idle", int'(state), int'(ST_IDLE));
        check("rs_busy_low", int'(busy), 0);
        check("rs_last_clear", int'(last_action), 0);
        step(2);
        reset_n = 1'b1;
        step(2);
        exp_q.delete();
        exp_q.push_back({3'd5, 4'd3});
        exp_q.push_back({3'd1, 4'd1});
        buttons = 8'h20;
        wait_valid(20, ok);
        check("rs_chat_valid", int'(ok), 1);
        check("rs_chat_state", int'(state), int'(ST_ISSUE1));
        step(2);
        buttons   = '0;
        req_ready = 1'b1;
        step(30);
        check("rs_chat_done", exp_q.size(), 0);
        check("rs_chat_last", int'(last_action), 5);
        check("rs_chat_idle", int'(state), int'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/care_actions.md
Name: care_actions

Overview:
Owner-side counterpart to the stat-growth logic.
- Turns raw care buttons (feed, play, medicine, bath, sleep, chat) into stat-decrement requests.
- Delivers requests over a valid/ready handshake to the stats owner, which applies them with saturation at 0.
- Debounces buttons, serialises multi-stat actions and enforces a cooldown between actions.

Parameters:
DEBOUNCE_CYCLES, 270000, cycles the synced button vector must be stable before it is accepted (10 ms at 27 MHz).
COOLDOWN_CYCLES, 27000000, idle cycles enforced after an action's last request (1 s at 27 MHz).

Ports:
clk  input  1  system clock (27 MHz)
reset_n  input  1  asynchronous, active-low reset
buttons  input  8  raw asynchronous buttons, active-high; bits 6..7 unused
random  input  5  free-running random bits from the existing source
req_valid  output  1  decrement request pending
req_sel  output  3  stat index: 0 hunger, 1 happiness, 2 health, 3 hygiene, 4 energy, 5 social
req_amt  output  4  decrement amount, 1..15
req_ready  input  1  stats owner accepts the request this cycle
busy  output  1  high whenever state is not IDLE
last_action  output  3  code of the most recently accepted action

Behaviour:
Reset (reset_n low, asynchronous):
- All outputs 0, state IDLE, all counters 0, synchronisers and debounced vector 0.
- Asserting reset mid-action or mid-cooldown abandons the action; no partial requests are replayed.

Input conditioning:
- Two-flop synchroniser on buttons.
- Shared stability counter clears whenever the synced vector changes.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced vector loads the synced vector.
- A press is a 0->1 edge on the debounced vector; it lasts one cycle per bit.

Action table (primary request, then optional secondary):
- 0 feed: hunger 4
- 1 play: happiness 3, then social 1
- 2 medicine: health 2+random[1:0] (2..5), sampled at acceptance
- 3 bath: hygiene 5
- 4 sleep: energy 6
- 5 chat: social 3, then happiness 1
- 6, 7: ignored, no state change

FSM states: IDLE, ISSUE1, ISSUE2, COOLDOWN.
- IDLE: on a press of a valid action, the lowest-index pressed bit wins and all others in that cycle are dropped.
  - latch action code into last_action and payload, go to ISSUE1.
  - req_valid rises the cycle after the press pulse.
- ISSUE1: req_valid=1 with the primary payload. On req_valid & req_ready, go to ISSUE2 if a secondary request exists, else COOLDOWN.
- ISSUE2: req_valid=1 with the secondary payload; handshake as in ISSUE1, then COOLDOWN.
  - Back-to-back transfers are allowed: with req_ready held high, the secondary is valid the cycle after the primary transfers.
- COOLDOWN: req_valid=0. Counter loads COOLDOWN_CYCLES-1 on entry and decrements; on 0, go to IDLE.
- Handshake rule: payload is registered and stable while req_valid=1 and !req_ready. req_valid never drops without a transfer, except on reset.
- Presses arriving outside IDLE are discarded, not queued. A button held through cooldown does not re-trigger; it must be released and pressed again.
- req_amt never exceeds 15; all amounts are 4-bit unsigned.

Optional Feature:
CARE_ACTIONS_BONUS_EN
- Defined: when random[4]=1 at acceptance, the primary amount is +1, saturating at 15 (feed becomes 5, medicine up to 6). Secondary requests are unchanged.
- Undefined: amounts are exactly as tabulated and random[4] is unused.

Decomposition:
Package care_pkg holds:
- stat index constants (STAT_HUNGER..STAT_SOCIAL)
- action codes (ACT_FEED..ACT_CHAT)
- per-action primary/secondary stat and amount constants
- FSM state enum

One sub-module: button_debounce (synchroniser, shared stability counter, edge detect, 8-bit press pulse output).

Test Plan:
Run with DEBOUNCE_CYCLES=4 and COOLDOWN_CYCLES=8.
1. Feed held 10 cycles, req_ready=1 -> one transfer sel=0 amt=4; busy for 1+8 cycles after the transfer; last_action=0.
2. Play with req_ready low for 5 cycles -> sel=1 amt=3 held stable for 5 cycles; after ready, sel=5 amt=1 the next cycle; then cooldown.
3. Buttons 0 and 3 rise in the same cycle -> only feed is issued. Bath pressed during cooldown -> no request; bath pressed again after IDLE -> sel=3 amt=5.
4. Button glitch of 2 cycles -> no request. Button bit 6 press -> nothing, busy stays 0.
5. Medicine with random=5'b00011 -> sel=2 amt=5. With CARE_ACTIONS_BONUS_EN and random=5'b10011 -> amt=6.
6. reset_n pulsed low while in ISSUE2 -> req_valid=0 and state IDLE immediately; the next press starts cleanly at ISSUE1.
